alu_mul_seq: RTL and testbench

- Bus-master sequencer that drives the alu block's control and data-in lines, the initiator side of the alu interface.
- Computes an 8x8 unsigned multiply (low byte plus sticky overflow) by shift-and-add, issuing alu write, shift, add and read cycles and capturing alu bus_out.
- Sits between the control unit and the alu; while busy it owns the alu port.

---
 rtl/alu_mul_seq_pkg.sv | 19 +
 rtl/alu_mul_seq.sv | 134 +++++++++++++
 tb/tb_alu_mul_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer that drives the alu port.
package alu_mul_seq_pkg;

  localparam int MUL_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    SCAN = 4'd1,
    LDA  = 4'd2,
    SHF  = 4'd3,
    RDS  = 4'd4,
    LDA2 = 4'd5,
    LDB  = 4'd6,
    ADD  = 4'd7,
    RDR  = 4'd8,
    DONE = 4'd9
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Bus-master sequencer: unsigned 8x8 multiply (low byte + sticky carry) by issuing
// alu write/shift/add/read cycles and accumulating the partial products.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_bus_in,
  output logic             alu_rega_we,
  output logic             alu_regb_we,
  output logic             alu_out_en,
  output logic             alu_sub,
  output logic             alu_shift,
  output logic [2:0]       alu_shift_pos,
  input  logic [WIDTH-1:0] alu_bus_out,
  input  logic             alu_carry
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] tmp;
  logic [2:0]       idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      tmp      <= '0;
      idx      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            acc      <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (b_q[idx]) begin
            state <= LDA;
          end else if (idx == 3'd7) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        LDA:  state <= SHF;
        SHF:  state <= RDS;
        RDS: begin
          tmp      <= alu_bus_out;
          overflow <= overflow | alu_carry;
          state    <= LDA2;
        end
        LDA2: state <= LDB;
        LDB:  state <= ADD;
        ADD:  state <= RDR;
        RDR: begin
          acc      <= alu_bus_out;
          overflow <= overflow | alu_carry;
          if (idx == 3'd7) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= SCAN;
          end
        end
        DONE: begin
          product <= acc;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control lines decode state only; reg_a and reg_b writes live in disjoint states.
  always_comb begin
    alu_bus_in    = '0;
    alu_rega_we   = 1'b0;
    alu_regb_we   = 1'b0;
    alu_out_en    = 1'b0;
    alu_sub       = 1'b0;
    alu_shift     = 1'b0;
    alu_shift_pos = '0;
    case (state)
      LDA: begin
        alu_rega_we = 1'b1;
        alu_bus_in  = a_q;
      end
      SHF: begin
        alu_shift     = 1'b1;
        alu_shift_pos = idx;
      end
      RDS:  alu_out_en = 1'b1;
      LDA2: begin
        alu_rega_we = 1'b1;
        alu_bus_in  = tmp;
      end
      LDB: begin
        alu_regb_we = 1'b1;
        alu_bus_in  = acc;
      end
      RDR:  alu_out_en = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq against a small behavioural alu (registers a/b, result, carry).
module tb_alu_mul_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       overflow;
  logic [7:0] alu_bus_in;
  logic       alu_rega_we;
  logic       alu_regb_we;
  logic       alu_out_en;
  logic       alu_sub;
  logic       alu_shift;
  logic [2:0] alu_shift_pos;
  logic [7:0] alu_bus_out;
  logic       alu_carry;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .overflow(overflow),
    .alu_bus_in(alu_bus_in), .alu_rega_we(alu_rega_we), .alu_regb_we(alu_regb_we),
    .alu_out_en(alu_out_en), .alu_sub(alu_sub), .alu_shift(alu_shift),
    .alu_shift_pos(alu_shift_pos), .alu_bus_out(alu_bus_out), .alu_carry(alu_carry)
  );

  // Behavioural alu: reg_a has write priority; result updates on shift, or add/sub when not driving.
  logic [7:0]  reg_a = '0;
  logic [7:0]  reg_b = '0;
  logic [7:0]  result = '0;
  logic        carry = 1'b0;
  logic [15:0] wide;
  logic [8:0]  sum;

  always @(posedge clk) begin
    if (alu_rega_we) reg_a <= alu_bus_in;
    else if (alu_regb_we) reg_b <= alu_bus_in;
    if (alu_shift) begin
      wide = {8'h00, reg_a} << alu_shift_pos;
      result <= wide[7:0];
      carry  <= |wide[15:8];
    end else if (!alu_out_en) begin
      sum = alu_sub ? ({1'b0, reg_a} - {1'b0, reg_b}) : ({1'b0, reg_a} + {1'b0, reg_b});
      result <= sum[7:0];
      carry  <= sum[8];
    end
  end

  assign alu_bus_out = alu_out_en ? result : 8'h00;
  assign alu_carry   = alu_out_en ? carry : 1'b0;

  always @(negedge clk) begin
    if (alu_rega_we || alu_regb_we) we_cnt++;
    if (alu_rega_we && alu_regb_we) both_cnt++;
    assert (!(alu_rega_we && alu_regb_we));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu_lines();
    return {16'h0, alu_rega_we, alu_regb_we, alu_out_en, alu_sub, alu_shift, alu_shift_pos, alu_bus_in};
  endfunction

  // Start in cycle 0; expect done in cycle exp_cyc, busy through it, results the cycle after.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_p, input logic exp_o, input int exp_cyc);
    int cyc;
    logic busy_bad;
    busy_bad = 1'b0;
    op_a = a; op_b = b; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (!busy) busy_bad = 1'b1;
      tick;
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_busy_hold"}, {busy_bad, busy}, 2'b01);
    tick;
    check({tag, "_busy_clr"}, {busy, done}, 2'b00);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_overflow"}, overflow, exp_o);
  endtask

  initial begin
    int cyc;
    int we_before;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    tick; tick;
    rst = 1'b0;
    check("reset_status", {busy, done, overflow, product}, 0);
    check("reset_alu", alu_lines(), 0);
    tick;

    run_op("m3x5", 8'd3, 8'd5, 8'd15, 1'b0, 23);
    run_op("m60x3", 8'h60, 8'd3, 8'h20, 1'b1, 23);
    we_before = we_cnt;
    run_op("mABx0", 8'hAB, 8'h00, 8'h00, 1'b0, 9);
    check("mABx0_no_we", we_cnt - we_before, 0);
    run_op("m1xFF", 8'h01, 8'hFF, 8'hFF, 1'b0, 65);

    // Extra start pulses mid-op and in DONE are ignored; the one right after DONE is taken.
    op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    tick;
    cyc = 1;
    start = 1'b0;
    while (cyc < 23) begin
      start = (cyc == 5) ? 1'b1 : 1'b0;
      op_a = 8'd9; op_b = 8'd9;
      tick;
      cyc++;
    end
    check("rep_done23", done, 1);
    start = 1'b1;
    tick;
    op_a = 8'd4; op_b = 8'd1;
    check("rep_idle24", busy, 0);
    check("rep_product", product, 15);
    tick;
    start = 1'b0;
    check("rep_accept24", busy, 1);
    cyc = 25;
    while (!done && cyc < 100) begin
      tick;
      cyc++;
    end
    check("rep_done_cycle", cyc, 40);
    tick;
    check("rep_product2", product, 4);

    // Reset in cycle 10 of a 7x7 op aborts it.
    op_a = 8'd7; op_b = 8'd7; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    rst = 1'b1;
    tick;
    check("abort_status", {busy, done, overflow, product}, 0);
    check("abort_alu", alu_lines(), 0);
    rst = 1'b0;
    tick;
    check("abort_idle", {busy, alu_lines()}, 0);
    run_op("m2x2", 8'd2, 8'd2, 8'd4, 1'b0, 16);

    check("we_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
